seq_div8by4: RTL and testbench

//  Multi-cycle restoring divider: the inverse operation of the team's K x K combinational array

---
 rtl/seq_div8by4_if.sv | 24 ++
 rtl/seq_div8by4.sv | 96 +++++++++
 tb/tb_seq_div8by4.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/seq_div8by4_if.sv
// Operand/result bundle for the sequential restoring divider.
// The master drives the request and operands; the slave (the divider) returns the results.
interface seq_div8by4_if #(
  parameter int K = 4
);
  logic           start;
  logic [2*K-1:0] dividend;
  logic [K-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [2*K-1:0] quotient;
  logic [K-1:0]   remainder;
  logic           div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div8by4.sv
// Multi-cycle restoring divider: a 2K-bit dividend divided by a K-bit divisor,
// one quotient bit per clock, with a start/done handshake.
module seq_div8by4 #(
  parameter int K = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_div8by4_if.slave     bus
);
  localparam int CW = $clog2(2 * K);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [2*K-1:0]  qsh_reg;
  logic [K-1:0]    prem_reg;
  logic [K-1:0]    dvs_reg;
  logic [2*K-1:0]  quo_reg;
  logic [K-1:0]    rem_reg;
  logic            dbz_reg;

  logic            accept;
  logic            last;
  logic            div_zero;
  logic [K:0]      p;
  logic            ge;
  logic [K-1:0]    rem_step;
  logic [2*K-1:0]  qsh_step;

  assign accept   = (state_reg != RUN) && bus.start;
  assign last     = (cnt_reg == CW'(2 * K - 1));
  assign div_zero = (bus.divisor == '0);

  // The partial remainder is always below the divisor, so K bits hold it between steps;
  // only the trial value p needs the extra bit.
  assign p        = {prem_reg, qsh_reg[2*K-1]};
  assign ge       = (p >= {1'b0, dvs_reg});
  assign rem_step = ge ? K'(p - {1'b0, dvs_reg}) : p[K-1:0];
  assign qsh_step = {qsh_reg[2*K-2:0], ge};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.start)
          state_next = div_zero ? DONE : RUN;
        else
          state_next = IDLE;
      end
      RUN: begin
        if (last)
          state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      qsh_reg   <= '0;
      prem_reg  <= '0;
      dvs_reg   <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        qsh_reg  <= bus.dividend;
        dvs_reg  <= bus.divisor;
        prem_reg <= '0;
        cnt_reg  <= '0;
        quo_reg  <= div_zero ? '1 : '0;
        rem_reg  <= '0;
        dbz_reg  <= div_zero;
      end else if (state_reg == RUN) begin
        prem_reg <= rem_step;
        qsh_reg  <= qsh_step;
        cnt_reg  <= cnt_reg + CW'(1);
        if (last) begin
          quo_reg <= qsh_step;
          rem_reg <= rem_step;
        end
      end
    end
  end

  assign bus.busy        = (state_reg == RUN);
  assign bus.done        = (state_reg == DONE);
  assign bus.quotient    = quo_reg;
  assign bus.remainder   = rem_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_div8by4.sv
// Directed and exhaustive checks of seq_div8by4 with a result scoreboard.
module tb_seq_div8by4;
  localparam int K = 4;

  typedef struct packed {
    logic [2*K-1:0] q;
    logic [K-1:0]   r;
    logic           z;
    logic [2*K-1:0] dd;
    logic [K-1:0]   dv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];

  seq_div8by4_if #(.K(K)) bus ();

  seq_div8by4 #(.K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2*K-1:0] dd, input logic [K-1:0] dv);
    exp_t e;
    e.dd = dd;
    e.dv = dv;
    if (dv == '0) begin
      e.q = '1;
      e.r = '0;
      e.z = 1'b1;
    end else begin
      e.q = dd / dv;
      e.r = dd % dv;
      e.z = 1'b0;
    end
    bus.start    = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    sb.push_back(e);
    cycle();
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 4'($urandom);
  endtask

  task automatic wait_done(output int cyc, input int max_cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < max_cyc) begin
      cycle();
      cyc++;
    end
  endtask

  // Results are compared on the falling edge of every done cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("result %0d/%0d", e.dd, e.dv),
            {18'd0, bus.busy, bus.quotient, bus.remainder, bus.div_by_zero},
            {18'd0, 1'b0, e.q, e.r, e.z});
        if (!e.z)
          chk($sformatf("invariant %0d/%0d", e.dd, e.dv),
              32'(bus.quotient) * 32'(e.dv) + 32'(bus.remainder), 32'(e.dd));
      end
    end
  end

  initial begin
    int c;
    int done_seen;

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #1;
    chk("reset_outputs", {18'd0, bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero}, 32'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // 225/15: latency and busy during RUN
    start_op(8'hE1, 4'hF);
    chk("busy_in_run", 32'(bus.busy), 32'd1);
    chk("outputs_cleared_on_start", {20'd0, bus.quotient, bus.remainder}, 32'd0);
    wait_done(c, 20);
    chk("latency_225_15", c, 8);

    // 100/7 then 255/1 back-to-back, then 0/9
    start_op(8'd100, 4'd7);
    wait_done(c, 20);
    chk("latency_100_7", c, 8);
    start_op(8'd255, 4'd1);
    wait_done(c, 20);
    chk("latency_b2b_255_1", c, 8);
    start_op(8'd0, 4'd9);
    wait_done(c, 20);
    chk("latency_0_9", c, 8);

    // Divide by zero, then a valid divide clears the flag
    start_op(8'd55, 4'd0);
    wait_done(c, 20);
    chk("latency_div0", c, 0);
    cycle();
    chk("div0_done_single", 32'(bus.done), 32'd0);
    start_op(8'd100, 4'd7);
    chk("dbz_cleared_on_start", 32'(bus.div_by_zero), 32'd0);
    wait_done(c, 20);
    chk("latency_after_div0", c, 8);

    // Start pulsed while busy is ignored
    start_op(8'd200, 4'd3);
    cycle();
    cycle();
    bus.start    = 1'b1;
    bus.dividend = 8'd10;
    bus.divisor  = 4'd5;
    cycle();
    bus.start    = 1'b0;
    wait_done(c, 20);
    chk("latency_ignored_start", 3 + c, 8);
    cycle();
    chk("idle_after_done", {30'd0, bus.busy, bus.done}, 32'd0);

    // Reset mid-RUN aborts the operation
    start_op(8'd123, 4'd4);
    cycle();
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {18'd0, bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero}, 32'd0);
    sb.delete();
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (bus.done === 1'b1) done_seen++;
      if (i == 2) rst_n = 1'b1;
    end
    chk("no_done_after_abort", done_seen, 0);
    start_op(8'd8, 4'd2);
    wait_done(c, 20);
    chk("latency_8_2", c, 8);

    // Exhaustive sweep of non-zero divisors, back-to-back
    for (int dd = 0; dd < 256; dd++) begin
      for (int dv = 1; dv < 16; dv++) begin
        start_op(8'(dd), 4'(dv));
        wait_done(c, 20);
        if (c != 8) chk($sformatf("latency_sweep %0d/%0d", dd, dv), c, 8);
      end
    end
    cycle();
    cycle();
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
